// File: rtl/cordic_sincos_pkg.sv
// Shared constants, types and helpers for the CORDIC sine/cosine engine.
package cordic_pkg;

  // Q-format widths: x/y are Q2.30 plus two guard bits, z is Q9.23 degrees.
  localparam int XY_W  = 34;
  localparam int Z_W   = 32;
  localparam int OUT_W = 32;
  localparam int IDX_W = 5;
  localparam int TAB_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // CORDIC gain compensation, 0.6072529 in Q2.30, widened to the x/y width.
  localparam logic signed [XY_W-1:0] K_XY = 34'sh026DD3B6A;

  // Angle thresholds in Q9.23 degrees.
  localparam logic signed [Z_W-1:0] POS_90  = 32'sh2D000000;
  localparam logic signed [Z_W-1:0] NEG_90  = 32'shD3000000;
  localparam logic signed [Z_W-1:0] POS_180 = 32'sh5A000000;
  localparam logic signed [Z_W-1:0] NEG_180 = 32'shA6000000;

  // Output clamp limits (+1.0 / -1.0 in Q2.30) at the x/y width.
  localparam logic signed [XY_W-1:0] OUT_MAX = 34'sh040000000;
  localparam logic signed [XY_W-1:0] OUT_MIN = 34'sh3C0000000;

  // atan(2^-i) in Q9.23 degrees.
  localparam logic signed [Z_W-1:0] ATAN_TAB [TAB_N] = '{
    32'sd377487360, 32'sd222843801, 32'sd117744544, 32'sd59768969,
    32'sd30000467,  32'sd15014858,  32'sd7509261,   32'sd3754860,
    32'sd1877459,   32'sd938733,    32'sd469367,    32'sd234683,
    32'sd117342,    32'sd58671,     32'sd29335,     32'sd14668,
    32'sd7334,      32'sd3667,      32'sd1833,      32'sd917,
    32'sd458,       32'sd229,       32'sd115,       32'sd57,
    32'sd29,        32'sd14,        32'sd7,         32'sd4,
    32'sd2,         32'sd1,         32'sd0,         32'sd0
  };

  // Clamp a guarded x/y value into [-1.0, +1.0] and drop the guard bits.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [XY_W-1:0] v);
    if (v > OUT_MAX) begin
      sat_out = 32'sh40000000;
    end else if (v < OUT_MIN) begin
      sat_out = 32'shC0000000;
    end else begin
      sat_out = v[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/cordic_sincos_if.sv
// Request/result bundle between a controller (master) and the CORDIC engine (slave).
interface cordic_sincos_if;
  logic        start;
  logic [31:0] angle;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] sin_out;
  logic [31:0] cos_out;

  modport master (output start, output angle,
                  input busy, input done, input err, input sin_out, input cos_out);
  modport slave  (input start, input angle,
                  output busy, output done, output err, output sin_out, output cos_out);
endinterface

// File: rtl/cordic_sincos_rot_stage.sv
// One combinational CORDIC rotation-mode micro-rotation.
module cordic_rot_stage
  import cordic_pkg::*;
(
  input  logic signed [XY_W-1:0]  x_i,
  input  logic signed [XY_W-1:0]  y_i,
  input  logic signed [Z_W-1:0]   z_i,
  input  logic        [IDX_W-1:0] idx_i,
  output logic signed [XY_W-1:0]  x_o,
  output logic signed [XY_W-1:0]  y_o,
  output logic signed [Z_W-1:0]   z_o
);

  logic signed [XY_W-1:0] x_sh_s;
  logic signed [XY_W-1:0] y_sh_s;
  logic signed [Z_W-1:0]  ang_s;

  // Rotate toward z = 0; direction follows the sign of the residual angle.
  always_comb begin
    x_sh_s = x_i >>> idx_i;
    y_sh_s = y_i >>> idx_i;
    ang_s  = ATAN_TAB[idx_i];
    if (z_i[Z_W-1] == 1'b0) begin
      x_o = x_i - y_sh_s;
      y_o = y_i + x_sh_s;
      z_o = z_i - ang_s;
    end else begin
      x_o = x_i + y_sh_s;
      y_o = y_i - x_sh_s;
      z_o = z_i + ang_s;
    end
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC engine: angle in Q9.23 degrees to (cos, sin) in Q2.30.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int ITER = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  cordic_sincos_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER - 1);

  state_t                 state_q, state_d;
  logic signed [XY_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [Z_W-1:0]  z_q, z_d;
  logic [IDX_W-1:0]       i_q, i_d;
  logic signed [OUT_W-1:0] sin_q, sin_d, cos_q, cos_d;
  logic                   err_q, err_d;
  logic                   busy_s, done_s;

  logic signed [XY_W-1:0] x_s, y_s;
  logic signed [Z_W-1:0]  z_s;
  logic signed [Z_W-1:0]  ang_s;
  logic                   oor_s;
  logic                   last_s;

  assign ang_s  = bus.angle;
  assign oor_s  = (ang_s >= POS_180) || (ang_s < NEG_180);
  assign last_s = (i_q == LAST_IDX);

  cordic_rot_stage u_stage (
    .x_i  (x_q),
    .y_i  (y_q),
    .z_i  (z_q),
    .idx_i(i_q),
    .x_o  (x_s),
    .y_o  (y_s),
    .z_o  (z_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; out-of-range requests skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = oor_s ? ST_DONE : ST_ITER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    busy_s = (state_q != ST_IDLE);
    done_s = (state_q == ST_DONE);
  end

  // Datapath next values: load with quadrant pre-rotation, iterate, capture result.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    i_d   = i_q;
    sin_d = sin_q;
    cos_d = cos_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          i_d = '0;
          x_d = K_XY;
          y_d = '0;
          z_d = ang_s;
          if (oor_s) begin
            err_d = 1'b1;
            sin_d = '0;
            cos_d = '0;
          end else begin
            err_d = 1'b0;
            // Fold |angle| > 90 into the CORDIC convergence range.
            if (ang_s > POS_90) begin
              x_d = '0;
              y_d = K_XY;
              z_d = ang_s - POS_90;
            end else if (ang_s < NEG_90) begin
              x_d = '0;
              y_d = -K_XY;
              z_d = ang_s + POS_90;
            end else begin
              z_d = ang_s;
            end
          end
        end else begin
          i_d = i_q;
        end
      end
      ST_ITER: begin
        x_d = x_s;
        y_d = y_s;
        z_d = z_s;
        i_d = i_q + 5'd1;
        if (last_s) begin
          sin_d = sat_out(y_s);
          cos_d = sat_out(x_s);
        end else begin
          sin_d = sin_q;
        end
      end
      ST_DONE: i_d = '0;
      default: i_d = '0;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      i_q   <= '0;
      sin_q <= '0;
      cos_q <= '0;
      err_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      i_q   <= i_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
      err_q <= err_d;
    end
  end

  assign bus.busy    = busy_s;
  assign bus.done    = done_s;
  assign bus.err     = err_q;
  assign bus.sin_out = sin_q;
  assign bus.cos_out = cos_q;

endmodule
